// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte queue and one-shot handshake sequencer feeding a UART transmitter
// UART_TXQ_GAP_EN builds the S_GAP state and its counter for inter-byte idle clocks.
module uart_tx_queue #(
    parameter logic [3:0]  p_DATA_BIT   = 4'd8,
    parameter int          p_DEPTH_LOG2 = 4,
    parameter logic [15:0] p_GAP        = 16'd0
) (
    input  logic                    i_local_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wr_en,
    input  logic [p_DATA_BIT-1:0]   i_wr_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [p_DEPTH_LOG2:0]   o_level,
    output logic                    o_ovf,
    input  logic                    i_ovf_clr,
    output logic                    o_tx_valid,
    output logic [p_DATA_BIT-1:0]   o_tx_data,
    input  logic                    i_tx_ready,
    output logic                    o_busy
);

    localparam int DEPTH = 1 << p_DEPTH_LOG2;
    localparam logic [p_DEPTH_LOG2:0] PTR_ONE = 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_BUSY = 3'd3;
`ifdef UART_TXQ_GAP_EN
    localparam logic [2:0] S_GAP  = 3'd4;
`endif

    logic [p_DATA_BIT-1:0]  mem [DEPTH];
    logic [p_DEPTH_LOG2:0]  wr_ptr;
    logic [p_DEPTH_LOG2:0]  rd_ptr;
    logic [2:0]             state;
    logic                   push;
    logic                   pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[p_DEPTH_LOG2] != rd_ptr[p_DEPTH_LOG2]) &&
                     (wr_ptr[p_DEPTH_LOG2-1:0] == rd_ptr[p_DEPTH_LOG2-1:0]);
    assign o_level = wr_ptr - rd_ptr;
    assign o_busy  = !o_empty || (state != S_IDLE);

    assign push = i_wr_en && !o_full;
    assign pop  = (state == S_IDLE) && !o_empty && i_tx_ready;

    always_ff @(posedge i_local_clk) begin
        if (push) begin
            mem[wr_ptr[p_DEPTH_LOG2-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_ovf  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (i_wr_en && o_full) begin
                o_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                o_ovf <= 1'b0;
            end
        end
    end

`ifdef UART_TXQ_GAP_EN
    logic [15:0] gap_cnt;
`else
    logic [15:0] unused_gap;
    assign unused_gap = p_GAP;
`endif

    // The sequencer demands a full ready low->high cycle before the next pop.
    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            o_tx_valid <= 1'b0;
            o_tx_data  <= '0;
`ifdef UART_TXQ_GAP_EN
            gap_cnt    <= 16'd0;
`endif
        end else begin
            o_tx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_tx_data  <= mem[rd_ptr[p_DEPTH_LOG2-1:0]];
                        o_tx_valid <= 1'b1;
                        state      <= S_SEND;
                    end
                end
                S_SEND: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!i_tx_ready) begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (i_tx_ready) begin
`ifdef UART_TXQ_GAP_EN
                        state   <= S_GAP;
                        gap_cnt <= 16'd0;
`else
                        state   <= S_IDLE;
`endif
                    end
                end
`ifdef UART_TXQ_GAP_EN
                S_GAP: begin
                    if ((p_GAP == 16'd0) || (gap_cnt == p_GAP - 16'd1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
